// File: rtl/pmm_result_reader_if.sv
// pmm_result_reader_if: CPU read bus plus PMM match/done inputs.
// master drives loads and match events, slave returns rdata.
interface pmm_result_reader_if;
  logic [31:0] daddr;
  logic        dre;
  logic [31:0] rdata;
  logic [3:0]  match_valid;
  logic [63:0] match_pos;
  logic [3:0]  pmm_done;

  modport master (
    output daddr, dre, match_valid, match_pos, pmm_done,
    input  rdata
  );

  modport slave (
    input  daddr, dre, match_valid, match_pos, pmm_done,
    output rdata
  );
endinterface

// File: rtl/pmm_result_reader.sv
// pmm_result_reader: PMM match holds drained round-robin into a result FIFO.
// Define PMM_RD_TIMESTAMP_EN to stamp each entry with a 16-bit cycle count.
module pmm_result_reader #(
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  pmm_result_reader_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef PMM_RD_TIMESTAMP_EN
  localparam int EW = 34;
`else
  localparam int EW = 18;
`endif

  logic [29:0]   a;
  logic          unused_ok;
  logic [3:0]    hold_v;
  logic [15:0]   hold_pos [4];
  logic [3:0]    ovf;
  logic [3:0]    done_q;
  logic [1:0]    rr_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] entry;
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          rd_status;
  logic          rd_result;
  logic          rd_ts;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          gnt_v;
  logic [1:0]    gnt_id;
  logic [3:0]    drain;
  logic [3:0]    load;
  logic [3:0]    ovf_set;
  logic [31:0]   rd_val;

`ifdef PMM_RD_TIMESTAMP_EN
  logic [15:0]   ts_cnt;
  logic [15:0]   hold_ts [4];
`endif

  assign a         = bus.daddr[31:2];
  assign unused_ok = ^bus.daddr[1:0];
  assign rd_status = bus.dre && (a == 30'd3);
  assign rd_result = bus.dre && (a == 30'd4);
  assign rd_ts     = bus.dre && (a == 30'd5);
  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = rd_result && !empty;
  assign head      = mem[rd_ptr];

  // First occupied hold at or after rr_ptr; lowest offset wins.
  always_comb begin
    logic [1:0] j;
    gnt_v  = 1'b0;
    gnt_id = 2'd0;
    j      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      j = rr_ptr + 2'(k);
      if (hold_v[j]) begin
        gnt_v  = 1'b1;
        gnt_id = j;
      end
    end
  end

  assign push    = gnt_v && (!full || pop);
  assign drain   = push ? (4'b1 << gnt_id) : 4'b0;
  assign load    = bus.match_valid & (~hold_v | drain);
  assign ovf_set = bus.match_valid & hold_v & ~drain;

`ifdef PMM_RD_TIMESTAMP_EN
  assign entry = {hold_ts[gnt_id], gnt_id, hold_pos[gnt_id]};
`else
  assign entry = {gnt_id, hold_pos[gnt_id]};
`endif

  always_comb begin
    rd_val = 32'h0;
    unique case (1'b1)
      rd_status: rd_val = {14'b0, full, empty, done_q, ovf, 8'(count)};
      rd_result: rd_val = pop ? {1'b1, 13'b0, head[17:0]} : 32'h0;
`ifdef PMM_RD_TIMESTAMP_EN
      rd_ts:     rd_val = empty ? 32'h0 : {16'h0, head[33:18]};
`else
      rd_ts:     rd_val = 32'h0;
`endif
      default:   rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v    <= 4'b0;
      ovf       <= 4'b0;
      done_q    <= 4'b0;
      rr_ptr    <= 2'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      bus.rdata <= 32'h0;
    end else begin
      hold_v <= (hold_v & ~drain) | load;
      // A same-cycle overflow survives the read-clear.
      ovf    <= (rd_status ? 4'b0 : ovf) | ovf_set;
      done_q <= bus.pmm_done;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= gnt_id + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.dre) bus.rdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        hold_pos[i] <= bus.match_pos[16*i +: 16];
`ifdef PMM_RD_TIMESTAMP_EN
        hold_ts[i]  <= ts_cnt;
`endif
      end
    end
  end

`ifdef PMM_RD_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= 16'h0;
    else       ts_cnt <= ts_cnt + 16'h1;
  end
`endif
endmodule
